tdc_event_sequencer: RTL and testbench

Upstream feeder for the histogram builder. Captures per-shot TDC timestamp events that arrive out of pixel order. At the end of each shot's capture window, it replays them as the strict serial stream the builder expects: pixel 0..PIXEL_NUM-1, DATA_NUM words per pixel, one word per clock under `wrEn`. Slots with no event are padded with all-ones, which the builder treats as "no photon" and does not bin.

---
 rtl/tdc_event_sequencer_if.sv | 23 ++
 rtl/tdc_event_sequencer.sv | 177 +++++++++++++++++
 tb/tb_tdc_event_sequencer.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/tdc_event_sequencer_if.sv
// Event input and serial output stream of the TDC event sequencer.
// The master side (event source / stream sink) drives events and observes the stream;
// the slave side (the sequencer) consumes events and drives the stream.
interface tdc_event_sequencer_if #(
  parameter int unsigned NP = 16,
  parameter int unsigned PW = 2
);
  logic          ev_valid;
  logic [PW-1:0] ev_pix;
  logic [NP-1:0] ev_ts;
  logic          wrEn;
  logic [NP-1:0] data;

  modport master (
    output ev_valid, ev_pix, ev_ts,
    input  wrEn, data
  );

  modport slave (
    input  ev_valid, ev_pix, ev_ts,
    output wrEn, data
  );
endinterface

// File: rtl/tdc_event_sequencer.sv
// TDC event sequencer: captures out-of-order per-pixel timestamps during a shot's window,
// then replays them as pixel-major, slot-minor serial words, padding empty slots with all-ones.
module tdc_event_sequencer #(
  parameter int unsigned NP         = 16,
  parameter int unsigned PIXEL_NUM  = 4,
  parameter int unsigned DATA_NUM   = 2,
  parameter int unsigned WIN_CYCLES = 64,
  parameter int unsigned PW         = (PIXEL_NUM > 1) ? $clog2(PIXEL_NUM) : 1
) (
  input  logic                        clk,
  input  logic                        res,
  input  logic                        shot_start,
  tdc_event_sequencer_if.slave        bus,
  output logic                        busy,
  output logic [7:0]                  ev_drop_cnt,
  output logic [7:0]                  shot_miss_cnt
);

  localparam int unsigned N  = PIXEL_NUM * DATA_NUM;
  localparam int unsigned WW = (WIN_CYCLES > 1) ? $clog2(WIN_CYCLES) : 1;
  localparam int unsigned CW = $clog2(DATA_NUM + 1);
  // drain_idx must be able to hold N (the "all words sent" value)
  localparam int unsigned IW = $clog2(N + 1);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StCapture = 2'd1;
  localparam logic [1:0] StDrain   = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [WW-1:0] win_cnt_q, win_cnt_d;
  logic [IW-1:0] drain_idx_q, drain_idx_d;
  logic [NP-1:0] ts_q [N];
  logic [NP-1:0] ts_d [N];
  logic [N-1:0]  fill_q, fill_d;
  logic [CW-1:0] fcnt_q [PIXEL_NUM];
  logic [CW-1:0] fcnt_d [PIXEL_NUM];
  logic          wren_q, wren_d;
  logic [NP-1:0] data_q, data_d;
  logic          busy_q, busy_d;
  logic [7:0]    drop_q, drop_d;
  logic [7:0]    miss_q, miss_d;

  logic [31:0]   pix_ext;
  logic          pix_ok, ts_ok, room, accept, drop, miss, shot_go;
  logic          emit;
  logic [IW-1:0] emit_idx;
  logic [NP-1:0] word;

  assign pix_ext = {{(32 - PW){1'b0}}, bus.ev_pix};
  assign pix_ok  = pix_ext < PIXEL_NUM;
  assign ts_ok   = bus.ev_ts != {NP{1'b1}};
  assign shot_go = (state_q == StIdle) && shot_start;
  assign accept  = (state_q == StCapture) && bus.ev_valid && pix_ok && ts_ok && room;
  assign drop    = bus.ev_valid && !accept;
  assign miss    = shot_start && (state_q != StIdle);

  // Does the addressed pixel still have a free slot?
  always_comb begin
    room = 1'b0;
    for (int p = 0; p < PIXEL_NUM; p++) begin
      if (pix_ext == p) room = (fcnt_q[p] != CW'(DATA_NUM));
    end
  end

  // Shot FSM: window timing and drain sequencing; word 0 is emitted on the edge leaving CAPTURE.
  always_comb begin
    state_d     = state_q;
    win_cnt_d   = win_cnt_q;
    drain_idx_d = drain_idx_q;
    emit        = 1'b0;
    emit_idx    = '0;
    unique case (state_q)
      StIdle: begin
        if (shot_start) begin
          state_d   = StCapture;
          win_cnt_d = '0;
        end
      end
      StCapture: begin
        win_cnt_d = win_cnt_q + 1'b1;
        if (win_cnt_q == WW'(WIN_CYCLES - 1)) begin
          state_d     = StDrain;
          emit        = 1'b1;
          emit_idx    = '0;
          drain_idx_d = IW'(1);
        end
      end
      StDrain: begin
        if (drain_idx_q == IW'(N)) begin
          state_d     = StIdle;
          drain_idx_d = '0;
        end else begin
          emit        = 1'b1;
          emit_idx    = drain_idx_q;
          drain_idx_d = drain_idx_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Slot storage: clear on shot acceptance, append accepted events in arrival order.
  always_comb begin
    ts_d   = ts_q;
    fill_d = fill_q;
    fcnt_d = fcnt_q;
    if (shot_go) begin
      fill_d = '0;
      for (int p = 0; p < PIXEL_NUM; p++) fcnt_d[p] = '0;
    end else if (accept) begin
      for (int p = 0; p < PIXEL_NUM; p++) begin
        if (pix_ext == p) begin
          fcnt_d[p] = fcnt_q[p] + 1'b1;
          for (int s = 0; s < DATA_NUM; s++) begin
            if (fcnt_q[p] == CW'(s)) begin
              ts_d[p * DATA_NUM + s]   = bus.ev_ts;
              fill_d[p * DATA_NUM + s] = 1'b1;
            end
          end
        end
      end
    end
  end

  // Drain word select; uses next-state slots so an event on the window's last edge reaches word 0.
  always_comb begin
    word = {NP{1'b1}};
    for (int k = 0; k < N; k++) begin
      if ((IW'(k) == emit_idx) && fill_d[k]) word = ts_d[k];
    end
  end

  // Registered outputs and saturating counters.
  always_comb begin
    wren_d = emit;
    data_d = emit ? word : data_q;
    busy_d = state_d != StIdle;
    drop_d = (drop && (drop_q != 8'hFF)) ? drop_q + 8'd1 : drop_q;
    miss_d = (miss && (miss_q != 8'hFF)) ? miss_q + 8'd1 : miss_q;
  end

  // State registers.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q     <= StIdle;
      win_cnt_q   <= '0;
      drain_idx_q <= '0;
      fill_q      <= '0;
      for (int k = 0; k < N; k++) ts_q[k] <= '0;
      for (int p = 0; p < PIXEL_NUM; p++) fcnt_q[p] <= '0;
      wren_q      <= 1'b0;
      data_q      <= '0;
      busy_q      <= 1'b0;
      drop_q      <= 8'd0;
      miss_q      <= 8'd0;
    end else begin
      state_q     <= state_d;
      win_cnt_q   <= win_cnt_d;
      drain_idx_q <= drain_idx_d;
      fill_q      <= fill_d;
      ts_q        <= ts_d;
      fcnt_q      <= fcnt_d;
      wren_q      <= wren_d;
      data_q      <= data_d;
      busy_q      <= busy_d;
      drop_q      <= drop_d;
      miss_q      <= miss_d;
    end
  end

  assign bus.wrEn      = wren_q;
  assign bus.data      = data_q;
  assign busy          = busy_q;
  assign ev_drop_cnt   = drop_q;
  assign shot_miss_cnt = miss_q;

endmodule

// File: tb/tb_tdc_event_sequencer.sv
// Bench for tdc_event_sequencer: shot-level reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_tdc_event_sequencer;
  localparam int unsigned NP  = 16;
  localparam int unsigned PIX = 4;
  localparam int unsigned DN  = 2;
  localparam int unsigned WIN = 8;
  localparam int unsigned PW  = 3;
  localparam int unsigned N   = PIX * DN;

  logic       clk = 1'b0;
  logic       res = 1'b0;
  logic       shot_start = 1'b0;
  logic       busy;
  logic [7:0] ev_drop_cnt, shot_miss_cnt;

  tdc_event_sequencer_if #(.NP(NP), .PW(PW)) bus ();

  tdc_event_sequencer #(
    .NP(NP), .PIXEL_NUM(PIX), .DATA_NUM(DN), .WIN_CYCLES(WIN), .PW(PW)
  ) dut (
    .clk           (clk),
    .res           (res),
    .shot_start    (shot_start),
    .bus           (bus),
    .busy          (busy),
    .ev_drop_cnt   (ev_drop_cnt),
    .shot_miss_cnt (shot_miss_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model (shot-level) ----------------
  bit          mbusy = 0;
  int          mt = 0;          // cycle number within the current shot
  logic        exp_wren = 0;
  logic        exp_busy = 0;
  logic [15:0] exp_data = 0;
  int          exp_drop = 0;
  int          exp_miss = 0;
  logic [15:0] mq [PIX][$];     // accepted timestamps per pixel, arrival order
  bit          cmp_en = 0;

  function automatic logic [15:0] mword(input int k);
    int p = k / DN;
    int s = k % DN;
    if (s < mq[p].size()) return mq[p][s];
    return 16'hFFFF;
  endfunction

  function automatic int sat(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge res);
      if (!res) begin
        mbusy = 0; mt = 0; exp_wren = 0; exp_busy = 0; exp_data = 0;
        exp_drop = 0; exp_miss = 0;
        for (int p = 0; p < PIX; p++) mq[p].delete();
      end else if (!mbusy) begin
        if (bus.ev_valid) exp_drop = sat(exp_drop + 1);
        exp_wren = 0;
        if (shot_start) begin
          mbusy = 1; mt = 0; exp_busy = 1;
          for (int p = 0; p < PIX; p++) mq[p].delete();
        end
      end else begin
        if (shot_start) exp_miss = sat(exp_miss + 1);
        if (bus.ev_valid) begin
          if (mt < WIN && int'(bus.ev_pix) < PIX && bus.ev_ts != 16'hFFFF
              && mq[int'(bus.ev_pix)].size() < DN)
            mq[int'(bus.ev_pix)].push_back(bus.ev_ts);
          else
            exp_drop = sat(exp_drop + 1);
        end
        mt++;
        if (mt < WIN) begin
          exp_wren = 0;
        end else if (mt < WIN + N) begin
          exp_wren = 1;
          exp_data = mword(mt - WIN);
        end else begin
          exp_wren = 0; exp_busy = 0; mbusy = 0;
        end
      end
    end
  end

  // Every-cycle comparison of DUT outputs against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        chk("cyc_wrEn", bus.wrEn, exp_wren);
        chk("cyc_data", bus.data, exp_data);
        chk("cyc_busy", busy, exp_busy);
        chk("cyc_drop", ev_drop_cnt, exp_drop);
        chk("cyc_miss", shot_miss_cnt, exp_miss);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  logic [15:0] got[$];

  task automatic tick(input bit ss, input bit ev, input logic [2:0] pix, input logic [15:0] ts);
    shot_start   = ss;
    bus.ev_valid = ev;
    bus.ev_pix   = pix;
    bus.ev_ts    = ts;
    @(negedge clk);
    if (bus.wrEn) got.push_back(bus.data);
  endtask

  task automatic wait_idle();
    int i = 0;
    while (busy && i < 200) begin
      tick(0, 0, 0, 0);
      i++;
    end
    chk("idle_reached", busy, 0);
  endtask

  task automatic check_words(input string nm, input logic [15:0] e [8]);
    chk($sformatf("%s_count", nm), got.size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < got.size()) chk($sformatf("%s_w%0d", nm, i), got[i], e[i]);
    end
  endtask

  int d0, m0, guard;

  initial begin
    bus.ev_valid = 0; bus.ev_pix = 0; bus.ev_ts = 0;
    repeat (2) @(negedge clk);
    chk("rst_wrEn", bus.wrEn, 0);
    chk("rst_data", bus.data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_drop", ev_drop_cnt, 0);
    chk("rst_miss", shot_miss_cnt, 0);
    res = 1'b1;
    cmp_en = 1;

    // Out-of-order events across pixels
    got.delete();
    tick(1, 0, 0, 0);
    chk("t1_busy_c0", busy, 1);
    tick(0, 1, 1, 16'h0100);
    tick(0, 1, 3, 16'h0200);
    tick(0, 1, 1, 16'h0150);
    wait_idle();
    check_words("t1", '{16'hFFFF, 16'hFFFF, 16'h0100, 16'h0150,
                        16'hFFFF, 16'hFFFF, 16'h0200, 16'hFFFF});
    chk("t1_drop", ev_drop_cnt, 0);
    chk("t1_model_w2", mword(2), 16'h0100);
    chk("t1_model_w3", mword(3), 16'h0150);
    chk("t1_model_w6", mword(6), 16'h0200);

    // Pixel overflow
    d0 = ev_drop_cnt;
    got.delete();
    tick(1, 0, 0, 0);
    tick(0, 1, 0, 16'h0011);
    tick(0, 1, 0, 16'h0022);
    tick(0, 1, 0, 16'h0033);
    wait_idle();
    check_words("t2", '{16'h0011, 16'h0022, 16'hFFFF, 16'hFFFF,
                        16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF});
    chk("t2_drop_delta", ev_drop_cnt - d0, 1);

    // Bad pixel, reserved timestamp, event during drain
    d0 = ev_drop_cnt;
    got.delete();
    tick(1, 0, 0, 0);
    tick(0, 1, 5, 16'h1234);
    tick(0, 1, 2, 16'hFFFF);
    tick(0, 1, 2, 16'h0AAA);
    repeat (WIN - 1) tick(0, 0, 0, 0);
    tick(0, 1, 0, 16'h0777);
    wait_idle();
    check_words("t3", '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF,
                        16'h0AAA, 16'hFFFF, 16'hFFFF, 16'hFFFF});
    chk("t3_drop_delta", ev_drop_cnt - d0, 3);

    // Ignored shots, including the final drain edge; back-to-back shot at WIN+N
    m0 = shot_miss_cnt;
    got.delete();
    tick(1, 0, 0, 0);
    for (int k = 0; k < WIN + N; k++) tick((k == 2) || (k == WIN + N - 1), 0, 0, 0);
    chk("t4_busy_low", busy, 0);
    chk("t4_burst_len", got.size(), 8);
    chk("t4_miss_delta", shot_miss_cnt - m0, 2);
    got.delete();
    tick(1, 0, 0, 0);
    chk("t4_restart", busy, 1);
    wait_idle();
    chk("t4_burst2_len", got.size(), 8);

    // Reset during drain word 3, then a clean shot
    got.delete();
    tick(1, 0, 0, 0);
    tick(0, 1, 0, 16'h0101);
    tick(0, 1, 1, 16'h0202);
    guard = 0;
    while (got.size() < 4 && guard < 100) begin
      tick(0, 0, 0, 0);
      guard++;
    end
    chk("t5_reached_w3", got.size(), 4);
    res = 1'b0;
    #1;
    chk("t5_rst_wrEn", bus.wrEn, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_data", bus.data, 0);
    chk("t5_rst_drop", ev_drop_cnt, 0);
    @(negedge clk);
    res = 1'b1;
    got.delete();
    tick(1, 0, 0, 0);
    wait_idle();
    check_words("t5", '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF,
                        16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF});

    // Randomized traffic
    repeat (400) begin
      tick($urandom_range(0, 15) == 0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
           ($urandom_range(0, 9) == 0) ? 16'hFFFF : 16'($urandom));
    end
    wait_idle();

    // Saturation of the drop counter
    repeat (300) tick(0, 1, 0, 16'h0010);
    chk("t7_drop_sat", ev_drop_cnt, 255);
    tick(0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time limit
  initial begin
    #500000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1);
  end

endmodule
